// File: rtl/es_sched_pkg.sv
// Shared types for the multiplier scheduler.
// FSM state encoding and watchdog counter sizing.
package es_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN,
    RESP
  } sched_state_t;

  function automatic int cnt_width(input int max_cycles);
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/es_rr_arbiter.sv
// Round-robin arbiter: lowest requester at or above ptr wins, wrapping.
// Purely combinational; grant is one-hot, idx is its encoded index.
module es_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

  always_comb begin : pick
    int   j;
    logic found;
    j     = 0;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/es_mul_scheduler.sv
// Shares one ordered CAS multiplier among NUM_REQ requesters,
// round-robin, with a watchdog on the run phase.
module es_mul_scheduler
  import es_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int WXIP1      = 1,
  parameter int NUM_REQ    = 4,
  parameter int MAX_CYCLES = 64
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       req_valid,
  output logic [NUM_REQ-1:0]                       req_ready,
  input  logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                       rsp_valid,
  input  logic [NUM_REQ-1:0]                       rsp_ready,
  output logic [WXIP1-1:0]                         rsp_data,
  output logic                                     rsp_err,
  output logic                                     busy,
  output logic                                     mul_clr,
  output logic                                     mul_en,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0]         mul_data,
  input  logic [WXIP1-1:0]                         mul_result,
  input  logic                                     mul_done
);

  localparam int OPW = NUM_INPUTS * DATA_WIDTH;
  localparam int IW  = $clog2(NUM_REQ);
  localparam int CW  = cnt_width(MAX_CYCLES);

  sched_state_t state, state_n;

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      gidx;
  logic [NUM_REQ-1:0] grant;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_n;
  logic               armed;
  logic               acc;
  logic               hit;
  logic               fin;

  // armed keeps the request side quiet until the first edge after reset
  es_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_arb (
    .req  (req_valid & {NUM_REQ{armed}}),
    .ptr  (ptr),
    .grant(grant),
    .idx  (gidx)
  );

  assign acc   = armed && (state == IDLE) && (|req_valid);
  assign cnt_n = cnt + CW'(1);
  assign hit   = (cnt_n == CW'(MAX_CYCLES));
  assign fin   = (state == RESP) && rsp_ready[owner];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (acc) state_n = CLR;
      CLR:     state_n = RUN;
      RUN:     if (mul_done || hit) state_n = RESP;
      RESP:    if (fin) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    mul_clr   = 1'b0;
    mul_en    = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE:    req_ready = grant;
      CLR:     mul_clr = 1'b1;
      RUN:     mul_en = 1'b1;
      RESP:    rsp_valid[owner] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed    <= 1'b0;
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
      mul_data <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      armed <= 1'b1;
      unique case (state)
        IDLE: if (acc) begin
          mul_data <= req_data[gidx*OPW +: OPW];
          owner    <= gidx;
        end
        CLR: cnt <= '0;
        RUN: begin
          cnt <= cnt_n;
          // done has priority over a coinciding watchdog expiry
          if (mul_done) begin
            rsp_data <= mul_result;
            rsp_err  <= 1'b0;
          end else if (hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        RESP: if (fin) begin
          if (owner == IW'(NUM_REQ - 1)) ptr <= '0;
          else                           ptr <= owner + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_es_mul_scheduler.sv
// Directed bench for es_mul_scheduler with a behavioural multiplier:
// result (a*b)>>5, done after a programmable number of enabled cycles.
module tb_es_mul_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [39:0] req_data;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [5:0]  rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        mul_clr;
  logic        mul_en;
  logic [9:0]  mul_data;
  logic [5:0]  mul_result;
  logic        mul_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mc     = 0;
  int done_at = 32;
  logic [9:0] prod;

  es_mul_scheduler #(
    .DATA_WIDTH(5),
    .NUM_INPUTS(2),
    .WXIP1     (6),
    .NUM_REQ   (4),
    .MAX_CYCLES(64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .mul_clr   (mul_clr),
    .mul_en    (mul_en),
    .mul_data  (mul_data),
    .mul_result(mul_result),
    .mul_done  (mul_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mul_clr)     mc <= 0;
    else if (mul_en) mc <= mc + 1;
  end

  assign prod       = mul_data[4:0] * mul_data[9:5];
  assign mul_result = prod[9:4] >> 1;
  assign mul_done   = mul_en && (mc == done_at);

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic put(input int r, input logic [4:0] a, input logic [4:0] b);
    req_data[r*10 +: 10] = {b, a};
    req_valid[r]         = 1'b1;
  endtask

  task automatic run_one(input int own, input logic [5:0] exp_d,
                         input logic exp_e, input int exp_lat,
                         input int hold);
    int         n;
    int         t0;
    int         bad;
    logic [3:0] v0;
    logic [5:0] d0;
    logic [9:0] ops;
    rsp_ready = (hold > 0) ? ~(4'b0001 << own) : 4'b1111;
    n = 0;
    #1;
    while (req_ready == 4'b0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("grant", req_ready, 4'b0001 << own);
    t0  = cyc;
    ops = req_data[own*10 +: 10];
    @(negedge clk);
    req_valid[own] = 1'b0;
    #1;
    check("clr", mul_clr, 1);
    check("mdata", mul_data, ops);
    bad = 0;
    n   = 0;
    while (rsp_valid == 4'b0 && n < 200) begin
      @(negedge clk); #1; n++;
      if (req_ready != 4'b0) bad++;
    end
    check("lat", cyc - t0, exp_lat);
    check("rspv", rsp_valid, 4'b0001 << own);
    check("rspd", rsp_data, exp_d);
    check("rspe", rsp_err, exp_e);
    check("noacc", bad, 0);
    if (hold > 0) begin
      v0  = rsp_valid;
      d0  = rsp_data;
      bad = 0;
      repeat (hold) begin
        @(negedge clk); #1;
        if (rsp_valid != v0 || rsp_data != d0 || req_ready != 4'b0 || mul_en)
          bad++;
      end
      check("hold", bad, 0);
      rsp_ready = 4'b1111;
    end
    @(negedge clk); #1;
    check("idle", busy, 0);
  endtask

  initial begin : main
    int n;
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    rsp_ready = 4'b1111;
    #12;
    check("rst_rdy", req_ready, 0);
    check("rst_out", {rsp_valid, rsp_data, rsp_err, busy, mul_clr, mul_en}, 0);
    check("rst_md", mul_data, 0);
    req_valid = 4'b0;
    @(negedge clk);
    rst = 1'b1;

    // contention: 0, 2, 3 then re-requesting 0 after 3
    put(0, 5'd31, 5'd31);
    put(2, 5'd10, 5'd20);
    put(3, 5'd7, 5'd9);
    run_one(0, 6'd30, 1'b0, 35, 0);
    put(0, 5'd20, 5'd24);
    run_one(2, 6'd6, 1'b0, 35, 0);
    run_one(3, 6'd1, 1'b0, 35, 0);
    run_one(0, 6'd15, 1'b0, 35, 0);

    // single request from requester 1
    put(1, 5'd16, 5'd8);
    run_one(1, 6'd4, 1'b0, 35, 0);

    // backpressure with requester 3 waiting
    put(2, 5'd30, 5'd17);
    run_one(2, 6'd15, 1'b0, 35, 10);
    put(3, 5'd3, 5'd21);
    run_one(3, 6'd1, 1'b0, 35, 0);

    // watchdog abort, then a normal request
    done_at = -1;
    put(0, 5'd5, 5'd5);
    run_one(0, 6'd0, 1'b1, 66, 0);
    done_at = 32;
    put(1, 5'd16, 5'd8);
    run_one(1, 6'd4, 1'b0, 35, 0);

    // done coincides with the 64th RUN cycle
    done_at = 63;
    put(2, 5'd31, 5'd31);
    run_one(2, 6'd30, 1'b0, 66, 0);
    done_at = 32;

    // reset during RUN
    put(3, 5'd1, 5'd1);
    n = 0;
    #1;
    while (req_ready == 4'b0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("mr_grant", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = 4'b0;
    repeat (11) @(negedge clk);
    #1;
    check("mr_en", mul_en, 1);
    rst = 1'b0;
    #1;
    check("mr_out", {rsp_valid, rsp_data, rsp_err, busy, mul_clr, mul_en}, 0);
    check("mr_md", mul_data, 0);
    put(0, 5'd3, 5'd11);
    put(3, 5'd24, 5'd24);
    repeat (2) @(negedge clk);
    #1;
    check("mr_rdy", req_ready, 0);
    check("mr_norsp", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    run_one(0, 6'd1, 1'b0, 35, 0);
    run_one(3, 6'd18, 1'b0, 35, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/es_mul_scheduler.md
# es_mul_scheduler

Sequencer and arbiter that shares one `es_ordered_cas_mul` instance among `NUM_REQ` requesters. Each requester hands over an operand vector with a valid/ready handshake. The scheduler grants requesters in round-robin order and clears and runs the multiplier until `done`, guarded by a watchdog. It returns the result to the granted requester through a valid/ready response channel. It sits between the requester fabric and the multiplier's `clk/rst/en/bin_data_in/bin_data_out/done` pins.

## Interface
- `DATA_WIDTH`, 5: operand width, matches multiplier.
- `NUM_INPUTS`, 2: operands per request, matches multiplier.
- `WXIP1`, 1: result width, matches multiplier.
- `NUM_REQ`, 4: number of requesters, ≥2.
- `MAX_CYCLES`, 64: watchdog limit on RUN cycles, ≥1.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: one-hot accept; at most one bit high.
- `req_data` in `NUM_REQ`×`NUM_INPUTS`×`DATA_WIDTH`: operand vectors.
- `rsp_valid` out `NUM_REQ`: one-hot response valid for the owning requester.
- `rsp_ready` in `NUM_REQ`: per-requester response accept.
- `rsp_data` out `WXIP1`: shared result bus.
- `rsp_err` out 1: result is a watchdog abort; qualified by `rsp_valid`.
- `busy` out 1: high in every state except IDLE.
- `mul_clr` out 1: active-high clear pulse to multiplier `rst`.
- `mul_en` out 1: multiplier `en`.
- `mul_data` out `NUM_INPUTS`×`DATA_WIDTH`: multiplier `bin_data_in`.
- `mul_result` in `WXIP1`: multiplier `bin_data_out`.
- `mul_done` in 1: multiplier `done`.

## Operation
- FSM states: IDLE, CLR, RUN, RESP.
- **IDLE**
  - If any `req_valid` is high, the round-robin arbiter picks grant `g`, and `req_ready[g]` is driven combinationally high that cycle.
  - On handshake, latch `req_data[g]` into `mul_data`, latch `g` into `owner`, and go to CLR.
- **CLR**: `mul_clr`=1 for exactly one cycle, `mul_en`=0, watchdog counter cleared; go to RUN.
- **RUN**
  - `mul_en`=1 and the counter increments each cycle.
  - `mul_done`=1: capture `mul_result` into `rsp_data`, set `rsp_err`=0, go to RESP.
  - Otherwise, when the counter reaches `MAX_CYCLES`: set `rsp_data`=0, `rsp_err`=1, go to RESP.
  - If `mul_done` and the limit coincide, done wins and `rsp_err`=0.
- **RESP**
  - `mul_en`=0; `rsp_valid[owner]`=1 and held with stable `rsp_data`/`rsp_err` until `rsp_ready[owner]`.
  - On handshake: the round-robin pointer becomes `owner+1` (mod `NUM_REQ`), then go to IDLE.
- Round robin: the search starts at the pointer, and the lowest index at or above the pointer wins, wrapping. The pointer moves only on response completion.
- Requester rules:
  - `req_valid`/`req_data` are held until `req_ready`.
  - `rsp_ready` from non-owners is ignored.
- `mul_done` outside RUN is ignored.
- `mul_data` holds the latched operands from CLR through RESP.

## Timing
- Reset (`rst`=0, asynchronous) values:
  - State IDLE, pointer 0, counter 0.
  - `req_ready`, `rsp_valid`, `rsp_data`, `rsp_err`, `busy`, `mul_clr`, `mul_en`, `mul_data` all 0.
- Assertion mid-operation aborts immediately. No response is issued for the in-flight request; it must be resubmitted.
- Deassertion is released on the next clock edge.
- Accept at cycle T (IDLE), then:
  - `mul_clr` high during T+1.
  - `mul_en` high from T+2.
  - `mul_done` first sampled at T+2+k.
  - `rsp_valid` high from T+3+k.
- Watchdog abort: `rsp_valid` rises `MAX_CYCLES` cycles after RUN entry.
- After the response handshake at cycle R, IDLE at R+1, so the next `req_ready` can occur at R+1.
- Single outstanding operation: `req_ready` is never high outside IDLE.

## Structure
- Package `es_sched_pkg` holds:
  - The `sched_state_t` enum (IDLE, CLR, RUN, RESP).
  - A function that computes the watchdog counter width as `$clog2(MAX_CYCLES+1)`.
- Sub-module `es_rr_arbiter`:
  - Inputs: `NUM_REQ`-bit request vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
- The top level holds the FSM, operand/owner/result registers, watchdog counter and pointer.

## Test plan
- Bench setup: `DATA_WIDTH`=5, `NUM_INPUTS`=2, `WXIP1`=6, `NUM_REQ`=4, `MAX_CYCLES`=64. The multiplier model returns `(a*b)>>5` with `done` 32 cycles after `en` rises.
- Single request: requester 1 sends {16,8}; `rsp_ready` tied high. Expect:
  - `req_ready`=4'b0010 for one cycle, then `mul_clr` for one cycle.
  - `rsp_valid`=4'b0010 with `rsp_data`=4, `rsp_err`=0, 35 cycles after accept.
- Contention: requesters 0, 2 and 3 all valid at once. Expect grant order 0, 2, 3. Requester 0 re-requests immediately and is served after 3.
- Backpressure: hold `rsp_ready[owner]`=0 for 10 cycles. Expect:
  - `rsp_valid` and `rsp_data` stable throughout.
  - No `req_ready` and `mul_en`=0.
  - Return to IDLE the cycle after release.
- Watchdog: model never asserts `done`. Expect `rsp_err`=1, `rsp_data`=0, `rsp_valid` 64 cycles after RUN entry. The next request is served normally.
- Coincidence: `done` on the 64th RUN cycle. Expect `rsp_err`=0 and the captured result.
- Reset mid-RUN: drop `rst` at cycle 10 of RUN. Expect:
  - All outputs 0 asynchronously, no response.
  - After release, the pointer is 0, so requester 0 wins over requester 3.
